dec_loop_ctrl: RTL and testbench

//  Down-count loop controller that sits directly upstream and downstream of the DEC stage.
//  - Registers a start value and drives it into DEC.
//  - Captures DEC's result back into its count register once per enabled cycle.
//  - Stops at zero and flags completion; handshake is start/busy/done/ack.
//  - Used by scheduled datapaths for loop-iteration counting.

---
 rtl/dec_loop_ctrl_pkg.sv | 20 ++
 rtl/dec_loop_ctrl_if.sv | 33 +++
 rtl/dec.sv | 15 +
 rtl/dec_loop_ctrl.sv | 84 ++++++++
 tb/tb_dec_loop_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/dec_loop_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dec_loop_ctrl_pkg
//  Description : Shared state encoding for the DEC-stage loop controller.
//  Revision    : 1.0  initial release
// ============================================================================
package dec_loop_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage : dec_loop_ctrl_pkg
`default_nettype wire

// File: rtl/dec_loop_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dec_loop_ctrl_if
//  Description : Handshake and DEC operand/result bundle for the loop controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface dec_loop_ctrl_if #(
    parameter int DATAWIDTH = 16
);
    logic                 start;
    logic [DATAWIDTH-1:0] load_val;
    logic                 en;
    logic                 ack;
    logic [DATAWIDTH-1:0] dec_a;
    logic [DATAWIDTH-1:0] dec_d;
    logic [DATAWIDTH-1:0] count;
    logic                 tick;
    logic                 busy;
    logic                 done;

    // Controller side
    modport slave (
        input  start, load_val, en, ack, dec_d,
        output dec_a, count, tick, busy, done
    );

    // Requester side (also carries the DEC result back)
    modport master (
        output start, load_val, en, ack, dec_d,
        input  dec_a, count, tick, busy, done
    );
endinterface : dec_loop_ctrl_if
`default_nettype wire

// File: rtl/dec.sv
`default_nettype none
// ============================================================================
//  Module      : dec
//  Description : Combinational decrement stage, d = a - 1 (wraps at zero).
//  Revision    : 1.0  initial release
// ============================================================================
module dec #(
    parameter int DATAWIDTH = 16
) (
    input  wire logic [DATAWIDTH-1:0] a,
    output logic      [DATAWIDTH-1:0] d
);
    assign d = a - DATAWIDTH'(1);
endmodule : dec
`default_nettype wire

// File: rtl/dec_loop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dec_loop_ctrl
//  Description : Down-count loop controller wrapped around an external DEC stage.
//  Revision    : 1.0  initial release
// ============================================================================
module dec_loop_ctrl
    import dec_loop_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 16
) (
    input  wire logic     Clk,
    input  wire logic     Rst,
    dec_loop_ctrl_if.slave bus
);

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_count;
    logic                 r_tick;
    logic                 r_busy;
    logic                 r_done;
    state_t               w_load_state;

    assign w_load_state = (bus.load_val != '0) ? S_RUN : S_DONE;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_count <= bus.load_val;
                        r_state <= w_load_state;
                        r_busy  <= (w_load_state == S_RUN);
                        r_done  <= (w_load_state == S_DONE);
                    end
                end
                S_RUN: begin
                    // The zero guard keeps DEC's 0-1 wrap from ever being captured
                    if (r_count == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (bus.en) begin
                        r_count <= bus.dec_d;
                        r_tick  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.ack) begin
                        if (bus.start) begin
                            r_count <= bus.load_val;
                            r_state <= w_load_state;
                            r_busy  <= (w_load_state == S_RUN);
                            r_done  <= (w_load_state == S_DONE);
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dec_a = r_count;
    assign bus.count = r_count;
    assign bus.tick  = r_tick;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule : dec_loop_ctrl
`default_nettype wire

// File: tb/tb_dec_loop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dec_loop_ctrl
//  Description : Scoreboard bench for dec_loop_ctrl with a DEC stage beside it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dec_loop_ctrl;

    localparam int DW = 16;

    typedef struct {
        int cnt;
        bit tk;
        bit bz;
        bit dn;
    } exp_t;

    logic Clk;
    logic Rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    // Reference state of the expected behaviour
    int m_st;
    int m_cnt;
    bit m_tk;
    bit m_bz;
    bit m_dn;

    int tick_tally;
    int busy_tally;

    dec_loop_ctrl_if #(.DATAWIDTH(DW)) bus ();

    dec_loop_ctrl #(.DATAWIDTH(DW)) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    dec #(.DATAWIDTH(DW)) u_dec (
        .a (bus.dec_a),
        .d (bus.dec_d)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_load(input int lv);
        m_cnt = lv;
        if (lv != 0) begin
            m_st = 1; m_bz = 1'b1; m_dn = 1'b0;
        end else begin
            m_st = 2; m_bz = 1'b0; m_dn = 1'b1;
        end
    endtask

    // One clock: drive, predict, push; then sample and compare the popped entry
    task automatic step(input bit s, input int lv, input bit e, input bit a,
                        input bit r, input string tag);
        exp_t x;
        exp_t y;
        @(negedge Clk);
        Rst          = r;
        bus.start    = s;
        bus.load_val = DW'(lv);
        bus.en       = e;
        bus.ack      = a;
        if (r) begin
            m_st = 0; m_cnt = 0; m_tk = 0; m_bz = 0; m_dn = 0;
        end else begin
            m_tk = 1'b0;
            case (m_st)
                0: if (s) model_load(lv);
                1: begin
                    if (m_cnt == 0) begin
                        m_st = 2; m_bz = 1'b0; m_dn = 1'b1;
                    end else if (e) begin
                        m_cnt = m_cnt - 1; m_tk = 1'b1;
                    end
                end
                default: begin
                    if (a) begin
                        if (s) model_load(lv);
                        else begin
                            m_st = 0; m_dn = 1'b0;
                        end
                    end
                end
            endcase
        end
        x.cnt = m_cnt; x.tk = m_tk; x.bz = m_bz; x.dn = m_dn;
        sb_q.push_back(x);
        @(posedge Clk);
        #1;
        y = sb_q.pop_front();
        check({tag, ".count"}, int'(bus.count), y.cnt);
        check({tag, ".dec_a"}, int'(bus.dec_a), y.cnt);
        check({tag, ".tick"},  int'(bus.tick),  int'(y.tk));
        check({tag, ".busy"},  int'(bus.busy),  int'(y.bz));
        check({tag, ".done"},  int'(bus.done),  int'(y.dn));
        if (bus.tick) tick_tally++;
        if (bus.busy) busy_tally++;
    endtask

    task automatic clear_tally();
        tick_tally = 0;
        busy_tally = 0;
    endtask

    initial begin
        checks = 0; failures = 0;
        m_st = 0; m_cnt = 0; m_tk = 0; m_bz = 0; m_dn = 0;
        Rst = 1'b1;
        bus.start = 1'b0; bus.load_val = '0; bus.en = 1'b0; bus.ack = 1'b0;
        clear_tally();

        // 1: reset
        step(0, 0, 0, 0, 1, "rst0");
        step(0, 0, 0, 0, 1, "rst1");
        step(0, 0, 0, 0, 0, "idle");
        check("rst.count_const", int'(bus.count), 0);

        // 2: load 3, free-running enable
        clear_tally();
        step(1, 3, 1, 0, 0, "t2.start");
        check("t2.loaded", int'(bus.count), 3);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, "t2.run");
        check("t2.ticks", tick_tally, 3);
        check("t2.busy_cycles", busy_tally, 4);
        check("t2.done_held", int'(bus.done), 1);
        step(0, 0, 1, 1, 0, "t2.ack");
        check("t2.idle_done", int'(bus.done), 0);

        // 3: zero load goes straight to done
        clear_tally();
        step(1, 0, 1, 0, 0, "t3.start");
        check("t3.done_now", int'(bus.done), 1);
        step(0, 0, 1, 0, 0, "t3.hold");
        check("t3.ticks", tick_tally, 0);
        check("t3.busy_cycles", busy_tally, 0);
        step(0, 0, 0, 1, 0, "t3.ack");

        // 4: pause after the second tick
        clear_tally();
        step(1, 5, 1, 0, 0, "t4.start");
        step(0, 0, 1, 0, 0, "t4.run");
        step(0, 0, 1, 0, 0, "t4.run");
        check("t4.at3", int'(bus.count), 3);
        step(0, 0, 0, 0, 0, "t4.pause");
        step(0, 0, 0, 0, 0, "t4.pause");
        check("t4.held3", int'(bus.count), 3);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, "t4.resume");
        check("t4.ticks", tick_tally, 5);
        check("t4.done", int'(bus.done), 1);
        step(0, 0, 0, 1, 0, "t4.ack");

        // 5: reset mid-run at count 2, then a clean reload
        step(1, 5, 1, 0, 0, "t5.start");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, "t5.run");
        check("t5.at2", int'(bus.count), 2);
        step(0, 0, 1, 0, 1, "t5.rst");
        check("t5.rst_busy", int'(bus.busy), 0);
        clear_tally();
        step(1, 2, 1, 0, 0, "t5.reload");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, "t5.run2");
        check("t5.ticks", tick_tally, 2);

        // 6: ack with start in DONE, and start ignored while running
        step(1, 1, 1, 1, 0, "t6.ackstart");
        check("t6.count1", int'(bus.count), 1);
        check("t6.busy", int'(bus.busy), 1);
        step(1, 9, 1, 0, 0, "t6.tick");
        check("t6.count0", int'(bus.count), 0);
        step(1, 7, 1, 0, 0, "t6.done");
        step(0, 0, 1, 1, 0, "t6.ack");
        step(1, 4, 1, 0, 0, "t6.start4");
        step(1, 9, 1, 0, 0, "t6.ign");
        check("t6.ignored", int'(bus.count), 3);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, "t6.run");
        step(0, 0, 1, 1, 0, "t6.ack2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dec_loop_ctrl
`default_nettype wire
